load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 2048, number of 32-bit words in the attached data memory.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  pipeline presents a memory request.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 SHALL have port req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err  output  1  request rejected, no memory access.
REQ-014 SHALL have port DMAddress  output  32  word index to data memory, {zeros, req_addr[31:2]}.
REQ-015 SHALL have port DMrd2  output  32  write data to data memory.
REQ-016 SHALL have port DMMemRead  output  1  read strobe.
REQ-017 SHALL have port DMMemWrite  output  1  write strobe; memory writes DMrd2 at the clk edge ending this cycle.
REQ-018 SHALL have port DMReadData  input  32  memory read data, valid one cycle after DMAddress is presented.

Function
REQ-019 SHALL register all outputs except req_ready, which SHALL equal (state==IDLE) once reset has been released for one edge.
REQ-020 SHALL implement states IDLE, ERR, RD, CAP, MERGE, WR, RESP.
REQ-021 SHALL accept a request in IDLE when req_valid && req_ready; the accept edge is T; all fields are latched at T.
REQ-022 SHALL go to ERR if req_size==11, the address is misaligned (half: addr[0]!=0; word: addr[1:0]!=0), or addr[31:2] >= MEM_WORDS; ERR cycle T+1 drives resp_valid=1, resp_err=1, resp_rdata=0, no strobes; then IDLE.
REQ-023 Load: RD at T+1 (DMMemRead=1, DMAddress valid); CAP at T+2 selects the byte lane (addr[1:0], little-endian) or halfword (addr[1]) from DMReadData and extends per req_unsigned; RESP at T+3 with resp_valid=1, resp_err=0.
REQ-024 Word store: WR at T+1 (DMMemWrite=1, DMrd2=req_wdata); RESP at T+2.
REQ-025 Byte/half store (read-modify-write): RD at T+1; MERGE at T+2 replaces only the addressed lane(s) of DMReadData with req_wdata[7:0]/[15:0] into DMrd2; WR at T+3; RESP at T+4.
REQ-026 SHALL assert DMMemRead only in RD and DMMemWrite only in WR; never both in one cycle.
REQ-027 SHALL hold DMAddress stable from RD/WR entry until RESP; SHALL drive 0 on DMMemRead/DMMemWrite in all other states.
REQ-028 SHALL assert resp_valid for exactly one cycle per accepted request; there is no response back-pressure.
REQ-029 SHALL ignore req_valid and all req_* inputs while not in IDLE; at most one request is in flight.
REQ-030 Back-to-back: a new request may be accepted on the edge leaving RESP/ERR (req_ready high in the following IDLE cycle, i.e. minimum one idle cycle between requests).

Reset
REQ-031 rst_n low SHALL immediately force state IDLE and resp_valid, resp_err, resp_rdata, DMAddress, DMrd2, DMMemRead, DMMemWrite, req_ready to 0.
REQ-032 req_ready SHALL rise at the first clk edge after rst_n deasserts; a reset mid-operation SHALL abort the access without any further strobe or response.

Verification
REQ-033 Memory word 5 = 0x000080F0; load byte addr 0x14 signed -> resp_rdata=0xFFFFFFF0 at T+3; load half 0x14 unsigned -> 0x000080F0; load byte 0x15 signed -> 0xFFFFFF80.
REQ-034 Store word 0xDEADBEEF to 0x20 -> DMMemWrite=1, DMAddress=8, DMrd2=0xDEADBEEF at T+1; resp_valid at T+2; subsequent load returns 0xDEADBEEF.
REQ-035 Word 3 = 0x11223344; store byte 0xAA to 0x0E -> DMrd2=0x11AA3344 written at T+3; resp_valid at T+4.
REQ-036 Load word at 0x02, half at 0x01, size 11, addr 0x2000 (MEM_WORDS=2048) -> resp_err=1 at T+1, no strobes.
REQ-037 Drop rst_n during MERGE of a half store -> outputs 0 at once, DMMemWrite never asserted, memory word unchanged, req_ready high one edge after release.
REQ-038 Hold req_valid high for 3 loads -> accepted only in IDLE cycles, exactly 3 resp_valid pulses, results in order.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between the pipeline and a synchronous single-port data memory.
// Handles sign/zero extension of loads and read-modify-write for sub-word stores.
module load_store_unit #(
   parameter int MEM_WORDS = 2048
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] DMAddress,
   output logic [31:0] DMrd2,
   output logic        DMMemRead,
   output logic        DMMemWrite,
   input  logic [31:0] DMReadData
);

   typedef enum logic [2:0] {IDLE, ERR, RD, CAP, MERGE, WR, RESP} state_t;

   localparam logic [1:0]  SZ_BYTE = 2'b00;
   localparam logic [1:0]  SZ_HALF = 2'b01;
   localparam logic [1:0]  SZ_WORD = 2'b10;
   localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

   state_t      state, next_state;
   logic        ready_en;
   logic        accept;
   logic        req_bad;

   logic        write_q;
   logic        unsigned_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;
   logic [31:0] merged;

   logic        resp_valid_d, resp_err_d, mem_read_d, mem_write_d;
   logic [31:0] resp_rdata_d, dm_addr_d, dm_wdata_d;

   // Ready stays low until one edge after reset release, then tracks IDLE.
   assign req_ready = ready_en && (state == IDLE);
   assign accept    = req_valid && req_ready;

   always_comb begin
      req_bad = 1'b0;
      case (req_size)
         SZ_HALF: req_bad = req_addr[0];
         SZ_WORD: req_bad = |req_addr[1:0];
         SZ_BYTE: req_bad = 1'b0;
         default: req_bad = 1'b1;
      endcase
      if (req_addr[31:2] >= WORD_LIMIT) req_bad = 1'b1;
   end

   // Little-endian lane selection and extension of the word returned by memory.
   always_comb begin
      case (addr_q[1:0])
         2'd0:    byte_sel = DMReadData[7:0];
         2'd1:    byte_sel = DMReadData[15:8];
         2'd2:    byte_sel = DMReadData[23:16];
         default: byte_sel = DMReadData[31:24];
      endcase
      half_sel = addr_q[1] ? DMReadData[31:16] : DMReadData[15:0];
      case (size_q)
         SZ_BYTE: load_ext = {{24{~unsigned_q & byte_sel[7]}}, byte_sel};
         SZ_HALF: load_ext = {{16{~unsigned_q & half_sel[15]}}, half_sel};
         default: load_ext = DMReadData;
      endcase
   end

   always_comb begin
      merged = DMReadData;
      if (size_q == SZ_BYTE) begin
         case (addr_q[1:0])
            2'd0:    merged[7:0]   = wdata_q[7:0];
            2'd1:    merged[15:8]  = wdata_q[7:0];
            2'd2:    merged[23:16] = wdata_q[7:0];
            default: merged[31:24] = wdata_q[7:0];
         endcase
      end else if (addr_q[1]) begin
         merged[31:16] = wdata_q[15:0];
      end else begin
         merged[15:0] = wdata_q[15:0];
      end
   end

   // Next state plus the values every registered output takes in that state.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned and infers a latch.
      next_state   = state;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = '0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      dm_addr_d    = DMAddress;
      dm_wdata_d   = DMrd2;
      case (state)
         IDLE: begin
            if (accept) begin
               if (req_bad) begin
                  next_state   = ERR;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else if (req_write && req_size == SZ_WORD) begin
                  next_state  = WR;
                  mem_write_d = 1'b1;
                  dm_addr_d   = {2'b00, req_addr[31:2]};
                  dm_wdata_d  = req_wdata;
               end else begin
                  next_state = RD;
                  mem_read_d = 1'b1;
                  dm_addr_d  = {2'b00, req_addr[31:2]};
               end
            end
         end
         ERR:  next_state = IDLE;
         RD:   next_state = write_q ? MERGE : CAP;
         CAP: begin
            next_state   = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = load_ext;
         end
         MERGE: begin
            next_state  = WR;
            mem_write_d = 1'b1;
            dm_wdata_d  = merged;
         end
         WR: begin
            next_state   = RESP;
            resp_valid_d = 1'b1;
         end
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
         state      <= IDLE;
         ready_en   <= 1'b0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         DMMemRead  <= 1'b0;
         DMMemWrite <= 1'b0;
         DMAddress  <= '0;
         DMrd2      <= '0;
      end else begin
         state      <= next_state;
         ready_en   <= 1'b1;
         resp_valid <= resp_valid_d;
         resp_err   <= resp_err_d;
         resp_rdata <= resp_rdata_d;
         DMMemRead  <= mem_read_d;
         DMMemWrite <= mem_write_d;
         DMAddress  <= dm_addr_d;
         DMrd2      <= dm_wdata_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_q    <= 1'b0;
         unsigned_q <= 1'b0;
         size_q     <= SZ_BYTE;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else if (accept) begin
         write_q    <= req_write;
         unsigned_q <= req_unsigned;
         size_q     <= req_size;
         addr_q     <= req_addr;
         wdata_q    <= req_wdata;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural synchronous data memory.
// Expected values are hand-computed constants.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_write, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] DMAddress, DMrd2, DMReadData;
   logic        DMMemRead, DMMemWrite;

   logic [31:0] mem [0:2047];
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_WORDS(2048)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .DMAddress(DMAddress), .DMrd2(DMrd2),
      .DMMemRead(DMMemRead), .DMMemWrite(DMMemWrite), .DMReadData(DMReadData)
   );

   // Synchronous memory: write at the edge ending a write cycle, data one cycle after address.
   always @(posedge clk) begin
      if (DMMemWrite) mem[DMAddress[10:0]] <= DMrd2;
      DMReadData <= mem[DMAddress[10:0]];
   end

   // Issues one request and observes eight cycles after the accept edge.
   task automatic issue(input logic w, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int n_rd, output int n_wr, output int n_resp,
                        output int wr_cyc, output logic [31:0] wr_data,
                        output logic [31:0] wr_addr, output logic [31:0] rd_addr);
      int waited = 0;
      lat = 0; rd = 'x; er = 'x; n_rd = 0; n_wr = 0; n_resp = 0;
      wr_cyc = 0; wr_data = '0; wr_addr = '0; rd_addr = '0;
      @(negedge clk);
      while (!req_ready && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) begin
         checks++; failures++;
         $display("FAIL issue_ready_timeout req_ready=%b required 1", req_ready);
      end
      req_write = w; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = 32'hFFFF_FFFF;
      req_wdata = 32'h0BAD_0BAD;
      for (int c = 1; c <= 8; c++) begin
         if (DMMemRead) begin n_rd++; rd_addr = DMAddress; end
         if (DMMemWrite) begin
            n_wr++; wr_cyc = c; wr_data = DMrd2; wr_addr = DMAddress;
         end
         if (resp_valid) begin
            n_resp++;
            if (lat == 0) begin lat = c; rd = resp_rdata; er = resp_err; end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({resp_valid, resp_err, DMMemRead, DMMemWrite, req_ready} !== 5'b0 ||
          resp_rdata !== 32'h0 || DMAddress !== 32'h0 || DMrd2 !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs got v=%b e=%b rd=%b wr=%b rdy=%b rdata=%h addr=%h wdata=%h required all 0",
                  resp_valid, resp_err, DMMemRead, DMMemWrite, req_ready, resp_rdata, DMAddress, DMrd2);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         failures++;
         $display("FAIL ready_before_edge got %b required 0", req_ready);
      end
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL ready_after_edge got %b required 1", req_ready);
      end
   endtask

   task automatic test_load();
      logic [1:0]  sz [6] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10};
      logic        un [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [31:0] ad [6] = '{32'h14, 32'h14, 32'h15, 32'h15, 32'h14, 32'h14};
      logic [31:0] ex [6] = '{32'hFFFF_FFF0, 32'h0000_80F0, 32'hFFFF_FF80,
                              32'h0000_0080, 32'hFFFF_80F0, 32'h0000_80F0};
      int lat, n_rd, n_wr, n_resp, wr_cyc;
      logic [31:0] rd, wr_data, wr_addr, rd_addr;
      logic er;
      mem[5] = 32'h0000_80F0;
      for (int i = 0; i < 6; i++) begin
         issue(1'b0, sz[i], un[i], ad[i], 32'h0, lat, rd, er, n_rd, n_wr, n_resp,
               wr_cyc, wr_data, wr_addr, rd_addr);
         checks++;
         if (lat !== 3 || rd !== ex[i] || er !== 1'b0 || n_resp !== 1) begin
            failures++;
            $display("FAIL load_%0d got lat=%0d data=%h err=%b pulses=%0d required lat=3 data=%h err=0 pulses=1",
                     i, lat, rd, er, n_resp, ex[i]);
         end
         checks++;
         if (n_rd !== 1 || n_wr !== 0 || rd_addr !== 32'd5) begin
            failures++;
            $display("FAIL load_strobe_%0d got reads=%0d writes=%0d addr=%h required reads=1 writes=0 addr=5",
                     i, n_rd, n_wr, rd_addr);
         end
      end
   endtask

   task automatic test_store_word();
      int lat, n_rd, n_wr, n_resp, wr_cyc;
      logic [31:0] rd, wr_data, wr_addr, rd_addr;
      logic er;
      issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, lat, rd, er, n_rd, n_wr, n_resp,
            wr_cyc, wr_data, wr_addr, rd_addr);
      checks++;
      if (wr_cyc !== 1 || wr_addr !== 32'd8 || wr_data !== 32'hDEAD_BEEF || n_wr !== 1 || n_rd !== 0) begin
         failures++;
         $display("FAIL store_word_strobe got cyc=%0d addr=%h data=%h writes=%0d reads=%0d required cyc=1 addr=8 data=deadbeef writes=1 reads=0",
                  wr_cyc, wr_addr, wr_data, n_wr, n_rd);
      end
      checks++;
      if (lat !== 2 || rd !== 32'h0 || er !== 1'b0) begin
         failures++;
         $display("FAIL store_word_resp got lat=%0d data=%h err=%b required lat=2 data=0 err=0", lat, rd, er);
      end
      issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, er, n_rd, n_wr, n_resp,
            wr_cyc, wr_data, wr_addr, rd_addr);
      checks++;
      if (lat !== 3 || rd !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL store_word_readback got lat=%0d data=%h required lat=3 data=deadbeef", lat, rd);
      end
   endtask

   task automatic test_store_subword();
      int lat, n_rd, n_wr, n_resp, wr_cyc;
      logic [31:0] rd, wr_data, wr_addr, rd_addr;
      logic er;
      mem[3] = 32'h1122_3344;
      issue(1'b1, 2'b00, 1'b0, 32'h0E, 32'h0000_00AA, lat, rd, er, n_rd, n_wr, n_resp,
            wr_cyc, wr_data, wr_addr, rd_addr);
      checks++;
      if (wr_cyc !== 3 || wr_data !== 32'h11AA_3344 || wr_addr !== 32'd3 || n_rd !== 1 || n_wr !== 1) begin
         failures++;
         $display("FAIL store_byte_rmw got cyc=%0d data=%h addr=%h reads=%0d writes=%0d required cyc=3 data=11aa3344 addr=3 reads=1 writes=1",
                  wr_cyc, wr_data, wr_addr, n_rd, n_wr);
      end
      checks++;
      if (lat !== 4 || rd !== 32'h0 || er !== 1'b0 || mem[3] !== 32'h11AA_3344) begin
         failures++;
         $display("FAIL store_byte_resp got lat=%0d data=%h err=%b mem=%h required lat=4 data=0 err=0 mem=11aa3344",
                  lat, rd, er, mem[3]);
      end
      issue(1'b1, 2'b01, 1'b0, 32'h0C, 32'h1234_BEEF, lat, rd, er, n_rd, n_wr, n_resp,
            wr_cyc, wr_data, wr_addr, rd_addr);
      checks++;
      if (lat !== 4 || wr_cyc !== 3 || mem[3] !== 32'h11AA_BEEF) begin
         failures++;
         $display("FAIL store_half_low got lat=%0d cyc=%0d mem=%h required lat=4 cyc=3 mem=11aabeef", lat, wr_cyc, mem[3]);
      end
      issue(1'b1, 2'b01, 1'b0, 32'h0E, 32'h0000_5A5A, lat, rd, er, n_rd, n_wr, n_resp,
            wr_cyc, wr_data, wr_addr, rd_addr);
      checks++;
      if (mem[3] !== 32'h5A5A_BEEF) begin
         failures++;
         $display("FAIL store_half_high got mem=%h required 5a5abeef", mem[3]);
      end
   endtask

   task automatic test_errors();
      logic [1:0]  sz [5] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b00};
      logic [31:0] ad [5] = '{32'h02, 32'h01, 32'h00, 32'h2000, 32'h1FFF};
      logic        be [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      int lat, n_rd, n_wr, n_resp, wr_cyc;
      logic [31:0] rd, wr_data, wr_addr, rd_addr;
      logic er;
      mem[2047] = 32'h7700_0000;
      for (int i = 0; i < 5; i++) begin
         issue(1'b0, sz[i], 1'b1, ad[i], 32'h0, lat, rd, er, n_rd, n_wr, n_resp,
               wr_cyc, wr_data, wr_addr, rd_addr);
         checks++;
         if (be[i]) begin
            if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || n_rd !== 0 || n_wr !== 0 || n_resp !== 1) begin
               failures++;
               $display("FAIL error_%0d got lat=%0d err=%b data=%h reads=%0d writes=%0d pulses=%0d required lat=1 err=1 data=0 no strobes pulses=1",
                        i, lat, er, rd, n_rd, n_wr, n_resp);
            end
         end else if (lat !== 3 || er !== 1'b0 || rd !== 32'h0000_0077) begin
            failures++;
            $display("FAIL last_word_load got lat=%0d err=%b data=%h required lat=3 err=0 data=00000077", lat, er, rd);
         end
      end
   endtask

   task automatic test_reset_mid();
      int bad = 0;
      mem[10] = 32'hCAFE_F00D;
      @(negedge clk);
      req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
      req_addr = 32'h28; req_wdata = 32'h0000_5555; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({resp_valid, resp_err, DMMemRead, DMMemWrite, req_ready} !== 5'b0 ||
          resp_rdata !== 32'h0 || DMAddress !== 32'h0 || DMrd2 !== 32'h0) begin
         failures++;
         $display("FAIL mid_reset_outputs got v=%b e=%b rd=%b wr=%b rdy=%b addr=%h wdata=%h required all 0",
                  resp_valid, resp_err, DMMemRead, DMMemWrite, req_ready, DMAddress, DMrd2);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (DMMemWrite || resp_valid) bad++;
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_ready_early got %b required 0", req_ready);
      end
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL mid_reset_ready got %b required 1", req_ready);
      end
      for (int c = 0; c < 4; c++) begin
         if (DMMemWrite || DMMemRead || resp_valid) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad !== 0 || mem[10] !== 32'hCAFE_F00D) begin
         failures++;
         $display("FAIL mid_reset_abort got stray=%0d mem=%h required stray=0 mem=cafef00d", bad, mem[10]);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ad [3] = '{32'h50, 32'h54, 32'h5B};
      logic [1:0]  sz [3] = '{2'b10, 2'b10, 2'b00};
      logic [31:0] ex [3] = '{32'h0101_0101, 32'h0202_0202, 32'hFFFF_FF83};
      int acc = 0;
      int nresp = 0;
      int early = 0;
      logic pending = 1'b0;
      mem[20] = 32'h0101_0101;
      mem[21] = 32'h0202_0202;
      mem[22] = 32'h8300_0000;
      @(negedge clk);
      req_write = 1'b0; req_unsigned = 1'b0; req_wdata = '0;
      req_addr = ad[0]; req_size = sz[0]; req_valid = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (resp_valid) begin
            checks++;
            if (nresp >= 3 || resp_rdata !== ex[nresp % 3]) begin
               failures++;
               $display("FAIL b2b_resp_%0d got %h required %h", nresp, resp_rdata, ex[nresp % 3]);
            end
            nresp++;
         end
         if (pending) begin
            acc++;
            if (acc < 3) begin
               req_addr = ad[acc]; req_size = sz[acc];
            end else begin
               req_valid = 1'b0;
            end
         end
         if (req_ready && acc > nresp) early++;
         pending = req_valid && req_ready;
         @(negedge clk);
      end
      checks++;
      if (acc !== 3 || nresp !== 3 || early !== 0) begin
         failures++;
         $display("FAIL b2b_counts got accepts=%0d responses=%0d ready_in_flight=%0d required 3 3 0", acc, nresp, early);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_store_word();
      test_store_subword();
      test_errors();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
